// File: rtl/cga_vram_host.sv
// cga_vram_host
//
// Bus-cycle initiator for port 0 of the CGA video RAM arbiter. CPU-side
// byte read/write requests arrive over a valid/ready handshake, are queued
// in strict FIFO order, and are replayed as correctly timed port-0 slots.
// A write slot is a WR_HOLD-cycle write level followed by a recovery gap,
// so that consecutive strobe starts are at least 8 cycles apart. A read
// slot is a read level held for RD_WAIT+1 cycles, after which the read
// data is returned.
//
// Parameters:
//   WR_HOLD        cycles isa_write is held high per write (3..7)
//   RD_WAIT        cycles isa_read is held before data is sampled (1..7)
//
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   req_valid      request present
//   req_ready      request accepted on req_valid & req_ready
//   req_write      1 = write, 0 = read
//   req_addr       19-bit byte address
//   req_wdata      write data (ignored for reads)
//   rd_valid       one-cycle pulse when rd_data is updated
//   rd_data        last read data, held until the next read completes
//   busy           queue non-empty or a slot in progress
//   isa_addr       port-0 address, held for the whole slot
//   isa_din        port-0 write data, held for the whole slot
//   isa_dout       port-0 read data
//   isa_read       port-0 read level
//   isa_write      port-0 write level (rising edge starts a write)
//   isa_op_enable  high while a read or write slot is active
//
// Configuration macro: CGA_VRAM_HOST_FIFO_EN
//   defined   : 4-entry command queue, requests are posted while slots run
//   undefined : single holding register, req_ready only when idle and empty

module cga_vram_host #(
   parameter int WR_HOLD = 7,
   parameter int RD_WAIT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [18:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rd_valid,
   output logic [7:0]  rd_data,
   output logic        busy,
   output logic [18:0] isa_addr,
   output logic [7:0]  isa_din,
   input  logic [7:0]  isa_dout,
   output logic        isa_read,
   output logic        isa_write,
   output logic        isa_op_enable
);

`ifdef CGA_VRAM_HOST_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = 3;
   // Recovery gap: fill up to 8 cycles after the write edge, at least 1.
   localparam int GAP_CYC = ((8 - WR_HOLD) < 1) ? 1 : (8 - WR_HOLD);

   localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_WAIT);
   localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_HI  = 2'd1,
      WR_GAP = 2'd2,
      RD     = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [27:0]      mem_q [DEPTH];
   logic [27:0]      mem_d [DEPTH];
   logic [18:0]      addr_q, addr_d;
   logic [7:0]       din_q, din_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             isa_write_q, isa_write_d;
   logic             isa_read_q, isa_read_d;
   logic             op_enable_q, op_enable_d;
   logic             busy_q, busy_d;

   logic             push;
   logic             pop;
   logic             slot_done;
   logic [27:0]      head;

   // Ready depends only on registered state, never on a same-cycle pop,
   // so a full queue turns away a request even while it is draining.
`ifdef CGA_VRAM_HOST_FIFO_EN
   assign req_ready = (count_q != 3'(DEPTH));
`else
   assign req_ready = (state_q == IDLE) && (count_q == 3'd0);
`endif

   assign push = req_valid && req_ready;
   assign head = mem_q[rd_ptr_q];

   // A slot ends on the last gap cycle of a write or the last read cycle.
   always_comb begin
      slot_done = 1'b0;
      case (state_q)
         WR_GAP:  slot_done = (cnt_q == GAP_LAST);
         RD:      slot_done = (cnt_q == RD_LAST);
         default: slot_done = 1'b0;
      endcase
   end

   // Popping straight out of a finishing slot (instead of passing through
   // IDLE) is what keeps queued writes on an exact 8-cycle cadence.
   assign pop = (count_q != 3'd0) && ((state_q == IDLE) || slot_done);

   // Queue bookkeeping: circular buffer with an occupancy count.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {req_write, req_addr, req_wdata};
         wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   // Slot sequencer. The address/data registers load only on a pop, so they
   // stay put through the write gap and the whole read.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 3'd1;
      addr_d     = addr_q;
      din_d      = din_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
         end
         WR_HI: begin
            if (cnt_q == WR_LAST) begin
               state_d = WR_GAP;
               cnt_d   = '0;
            end
         end
         WR_GAP: begin
            if (slot_done) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         RD: begin
            if (slot_done) begin
               state_d    = IDLE;
               cnt_d      = '0;
               rd_data_d  = isa_dout;
               rd_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      if (pop) begin
         state_d = head[27] ? WR_HI : RD;
         cnt_d   = '0;
         addr_d  = head[26:8];
         din_d   = head[7:0];
      end
   end

   // Strobes come from flops decoded off the next state, so a multi-bit
   // state change can never glitch isa_read high during a write slot.
   always_comb begin
      isa_write_d = (state_d == WR_HI);
      isa_read_d  = (state_d == RD);
      op_enable_d = (state_d != IDLE);
      busy_d      = (state_d != IDLE) || (count_d != 3'd0);
   end

   // Control and output registers; reset drops the strobes immediately and
   // empties the queue by clearing the count and pointers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         addr_q      <= '0;
         din_q       <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         isa_write_q <= 1'b0;
         isa_read_q  <= 1'b0;
         op_enable_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         isa_write_q <= isa_write_d;
         isa_read_q  <= isa_read_d;
         op_enable_q <= op_enable_d;
         busy_q      <= busy_d;
      end
   end

   // Queue storage needs no reset: entries are only read while counted.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_valid      = rd_valid_q;
   assign rd_data       = rd_data_q;
   assign busy          = busy_q;
   assign isa_addr      = addr_q;
   assign isa_din       = din_q;
   assign isa_read      = isa_read_q;
   assign isa_write     = isa_write_q;
   assign isa_op_enable = op_enable_q;

endmodule

// File: tb/tb_cga_vram_host.sv
// tb_cga_vram_host
//
// Scoreboard bench for cga_vram_host. Each issued request pushes the strobe
// it should produce (kind, address, data, spacing from the previous strobe
// start); read requests also push the data the port-0 model returns. A
// monitor watches the port-0 strobes and rd_valid and pops/compares.
// Builds with or without CGA_VRAM_HOST_FIFO_EN.

module tb_cga_vram_host;

   localparam int WR_HOLD = 7;
   localparam int RD_WAIT = 2;

`ifdef CGA_VRAM_HOST_FIFO_EN
   localparam int GAP_WR_RD = 8;
   localparam int GAP_RD_RD = 3;
`else
   localparam int GAP_WR_RD = 10;
   localparam int GAP_RD_RD = 5;
`endif

   typedef struct {
      logic        wr;
      logic [18:0] addr;
      logic [7:0]  data;
      int          gap;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [18:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        busy;
   logic [18:0] isa_addr;
   logic [7:0]  isa_din;
   logic [7:0]  isa_dout;
   logic        isa_read;
   logic        isa_write;
   logic        isa_op_enable;

   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;

   exp_t        exp_q[$];
   logic [7:0]  rd_q[$];

   int          strobe_count = 0;
   int          rdv_count = 0;
   int          wr_rise_cyc = -100;
   int          rd_rise_cyc = -100;
   int          last_start = -100;
   logic        prev_wr = 1'b0;
   logic        prev_rd = 1'b0;
   logic        stable_bad = 1'b0;
   logic [18:0] cap_addr = '0;
   logic [7:0]  cap_din = '0;

   cga_vram_host #(
      .WR_HOLD(WR_HOLD),
      .RD_WAIT(RD_WAIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .busy         (busy),
      .isa_addr     (isa_addr),
      .isa_din      (isa_din),
      .isa_dout     (isa_dout),
      .isa_read     (isa_read),
      .isa_write    (isa_write),
      .isa_op_enable(isa_op_enable)
   );

   // Port-0 read model: fixed bytes at two addresses, 0xFF elsewhere.
   assign isa_dout = (isa_addr == 19'h00010) ? 8'h3C :
                     (isa_addr == 19'h00040) ? 8'h5A : 8'hFF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle k is the period that follows the k-th rising edge.
   always @(posedge clk) cyc++;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
      checks++;
      if (actual === required) passes++;
      else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)",
                    name, actual, required, cyc);
   endtask

   // Issue one request, push its expected strobe, and hold it until taken.
   task automatic apply_stimulus(input logic wr, input logic [18:0] addr,
                                 input logic [7:0] data, input int gap,
                                 output int acc);
      exp_t e;
      int   waited;
      e.wr = wr; e.addr = addr; e.data = data; e.gap = gap;
      exp_q.push_back(e);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = data;
      @(negedge clk);
      waited = 0;
      while (!req_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) check_output("accept_timeout", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_output("drain_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: strobe starts pop the expected-strobe queue, rd_valid pops the
   // expected-data queue; hold widths and spacing are measured in cycles.
   always @(negedge clk) begin
      logic wr_start;
      logic rd_start;
      exp_t e;
      if (reset) begin
         prev_wr = 1'b0;
         prev_rd = 1'b0;
      end else begin
         if (rd_valid) begin
            rdv_count++;
            if (rd_q.size() == 0) begin
               check_output("rd_valid_unexpected", 32'(rd_valid), 32'd0);
            end else begin
               check_output("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            end
            check_output("rd_valid_latency", 32'(cyc - rd_rise_cyc), 32'(RD_WAIT + 1));
         end
         wr_start = isa_write && !prev_wr;
         rd_start = isa_read && (!prev_rd || (cyc - rd_rise_cyc == RD_WAIT + 1));
         if (prev_wr && !isa_write) begin
            check_output("wr_width", 32'(cyc - wr_rise_cyc), 32'(WR_HOLD));
            check_output("wr_hold_stable", 32'(stable_bad), 32'd0);
         end
         if (prev_rd && !isa_read)
            check_output("rd_width", 32'(cyc - rd_rise_cyc), 32'(RD_WAIT + 1));
         if (isa_write && prev_wr && (isa_addr != cap_addr || isa_din != cap_din))
            stable_bad = 1'b1;
         if (wr_start || rd_start) begin
            strobe_count++;
            if (exp_q.size() == 0) begin
               check_output("strobe_unexpected", {30'd0, isa_write, isa_read}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_output("strobe_kind", {30'd0, isa_write, isa_read},
                            e.wr ? 32'd2 : 32'd1);
               check_output("strobe_addr", 32'(isa_addr), 32'(e.addr));
               if (e.wr) check_output("strobe_din", 32'(isa_din), 32'(e.data));
               if (e.gap != 0)
                  check_output("strobe_spacing", 32'(cyc - last_start), 32'(e.gap));
            end
            last_start = cyc;
            if (wr_start) begin
               wr_rise_cyc = cyc;
               cap_addr    = isa_addr;
               cap_din     = isa_din;
               stable_bad  = 1'b0;
            end
            if (rd_start) rd_rise_cyc = cyc;
         end
         prev_wr = isa_write;
         prev_rd = isa_read;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc [6];
      int n;
      int strobes_before;
      int rdv_before;

      reset     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check_output("rst_levels", {27'd0, isa_read, isa_write, isa_op_enable, rd_valid, busy}, 32'd0);
      check_output("rst_isa_addr", 32'(isa_addr), 32'd0);
      check_output("rst_isa_din", 32'(isa_din), 32'd0);
      check_output("rst_rd_data", 32'(rd_data), 32'd0);
      check_output("rst_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #2; reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Single write: strobe on a+1..a+7, gap a+8, idle a+9
      apply_stimulus(1'b1, 19'h00123, 8'hA5, 0, acc[0]);
      @(negedge clk);
      check_output("t1_pre_edge", {30'd0, isa_write, busy}, 32'd1);
      @(negedge clk);
      check_output("t1_edge", 32'(isa_write), 32'd1);
      repeat (6) @(negedge clk);
      check_output("t1_last_hi", 32'(isa_write), 32'd1);
      @(negedge clk);
      check_output("t1_gap_levels", {29'd0, isa_write, isa_op_enable, busy}, 32'd3);
      check_output("t1_gap_addr", 32'(isa_addr), 32'h00123);
      check_output("t1_gap_din", 32'(isa_din), 32'hA5);
      @(negedge clk);
      check_output("t1_idle", {29'd0, isa_op_enable, busy, req_ready}, 32'd1);
      @(posedge clk); #1;

`ifdef CGA_VRAM_HOST_FIFO_EN
      // Back-to-back writes; the sixth waits for the second pop
      apply_stimulus(1'b1, 19'h00200, 8'h01, 0, acc[0]);
      apply_stimulus(1'b1, 19'h00201, 8'h02, 8, acc[1]);
      apply_stimulus(1'b1, 19'h00202, 8'h03, 8, acc[2]);
      apply_stimulus(1'b1, 19'h00203, 8'h04, 8, acc[3]);
      apply_stimulus(1'b1, 19'h00204, 8'h05, 8, acc[4]);
      apply_stimulus(1'b1, 19'h00205, 8'h06, 8, acc[5]);
      check_output("t2_no_stall", 32'(acc[4] - acc[0]), 32'd4);
      check_output("t2_full_wait", 32'(acc[5] - acc[0]), 32'd10);
`else
      // Second request held off until the first slot is back in IDLE
      apply_stimulus(1'b1, 19'h00200, 8'h01, 0, acc[0]);
      apply_stimulus(1'b1, 19'h00201, 8'h02, 10, acc[1]);
      check_output("t2_held_off", 32'(acc[1] - acc[0]), 32'd10);
`endif
      wait_idle(200);

      // Write, then two reads
      apply_stimulus(1'b1, 19'h00020, 8'h11, 0, acc[0]);
      rd_q.push_back(8'h3C);
      apply_stimulus(1'b0, 19'h00010, 8'h00, GAP_WR_RD, acc[1]);
      rd_q.push_back(8'h5A);
      apply_stimulus(1'b0, 19'h00040, 8'h00, GAP_RD_RD, acc[2]);
      wait_idle(200);
      repeat (3) @(negedge clk);
      check_output("t3_rd_data_held", 32'(rd_data), 32'h5A);
      check_output("t3_rd_valid_low", 32'(rd_valid), 32'd0);
      check_output("t3_rd_count", 32'(rdv_count), 32'd2);
      @(posedge clk); #1;

      // Reset during WR_HI with entries queued
`ifdef CGA_VRAM_HOST_FIFO_EN
      apply_stimulus(1'b1, 19'h00300, 8'h21, 0, acc[0]);
      apply_stimulus(1'b1, 19'h00301, 8'h22, 0, acc[1]);
      apply_stimulus(1'b1, 19'h00302, 8'h23, 0, acc[2]);
`else
      apply_stimulus(1'b1, 19'h00300, 8'h21, 0, acc[0]);
`endif
      n = 0;
      while (!isa_write && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_output("t4_in_wr_hi", 32'(isa_write), 32'd1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check_output("t4_rst_levels", {28'd0, isa_write, isa_read, isa_op_enable, busy}, 32'd0);
      check_output("t4_rst_ready", 32'(req_ready), 32'd1);
      exp_q.delete();
      rd_q.delete();
      strobes_before = strobe_count;
      rdv_before     = rdv_count;
      @(posedge clk); #2;
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check_output("t4_no_strobes", 32'(strobe_count), 32'(strobes_before));
      check_output("t4_idle", {30'd0, busy, isa_op_enable}, 32'd0);
      @(posedge clk); #1;

      // Reset during a read: no rd_valid for the aborted read
      apply_stimulus(1'b0, 19'h00010, 8'h00, 0, acc[0]);
      n = 0;
      while (!isa_read && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_output("t5_in_rd", 32'(isa_read), 32'd1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check_output("t5_rst_read", 32'(isa_read), 32'd0);
      exp_q.delete();
      strobes_before = strobe_count;
      @(posedge clk); #2;
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check_output("t5_no_rd_valid", 32'(rdv_count), 32'(rdv_before));
      check_output("t5_no_strobes", 32'(strobe_count), 32'(strobes_before));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
